i2c_arbiter: RTL and testbench

I2C_ARBITER -- requirements
Module: i2c_arbiter

---
 rtl/i2c_arbiter.sv | 178 +++++++++++++++++
 tb/tb_i2c_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_arbiter.sv
// Two-requester round-robin front end for a single I2C master: grants one
// transaction at a time, sequences the master handshake, and reports results.
module i2c_arbiter #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd2000000
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic [1:0]  req,
   input  logic [1:0]  req_write,
   input  logic [13:0] req_addr,
   input  logic [7:0]  req_mask,
   input  logic [63:0] req_wdata,
   output logic [1:0]  done,
   output logic [31:0] rdata,
   output logic [2:0]  err,
   output logic        ctrl_busy,
   output logic        m_reset,
   output logic [6:0]  m_device_addr,
   output logic [3:0]  m_mask,
   output logic [31:0] m_data_in,
   output logic        m_write,
   input  logic        m_busy,
   input  logic [31:0] m_data_out,
   input  logic [4:0]  m_acks
);

   localparam int unsigned AW = 7;
   localparam int unsigned MW = 4;
   localparam int unsigned DW = 32;
   localparam int unsigned CW = 24;

   typedef enum logic [2:0] {
      S_IDLE, S_LAUNCH, S_WAIT_START, S_WAIT_DONE, S_RESPOND
   } state_e;

   state_e          state_q, state_d;
   logic [AW-1:0]   addr_q, addr_d;
   logic [MW-1:0]   mask_q, mask_d;
   logic [DW-1:0]   wdata_q, wdata_d;
   logic            write_q, write_d;
   logic            winner_q, winner_d;
   logic            last_q, last_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [1:0]      done_q, done_d;
   logic [DW-1:0]   rdata_q, rdata_d;
   logic [2:0]      err_q, err_d;
   logic            busy_q, busy_d;
   logic            m_reset_q, m_reset_d;

   logic            win_c;
   logic [MW-1:0]   sel_mask_c;
   logic [CW-1:0]   cnt_inc_c;
   logic            nack_c;

   assign cnt_inc_c = cnt_q + CW'(1);
   assign nack_c    = m_acks[4] | (write_q & (|(m_acks[3:0] & mask_q)));

   // Next-state, transaction latch and result capture
   always_comb begin
      state_d    = state_q;
      addr_d     = addr_q;
      mask_d     = mask_q;
      wdata_d    = wdata_q;
      write_d    = write_q;
      winner_d   = winner_q;
      last_d     = last_q;
      cnt_d      = cnt_q;
      rdata_d    = rdata_q;
      err_d      = err_q;
      win_c      = 1'b0;
      sel_mask_c = '0;

      case (state_q)
         S_IDLE: begin
            if (|req) begin
               // On a tie the requester not served last wins
               win_c      = (req == 2'b11) ? ~last_q : req[1];
               sel_mask_c = win_c ? req_mask[7:4] : req_mask[3:0];
               winner_d   = win_c;
               addr_d     = win_c ? req_addr[13:7] : req_addr[6:0];
               mask_d     = sel_mask_c;
               wdata_d    = win_c ? req_wdata[63:32] : req_wdata[31:0];
               write_d    = win_c ? req_write[1] : req_write[0];
               if (sel_mask_c == '0) begin
                  err_d   = 3'b010;
                  state_d = S_RESPOND;
               end else begin
                  state_d = S_LAUNCH;
               end
            end
         end
         S_LAUNCH: begin
            cnt_d   = '0;
            state_d = S_WAIT_START;
         end
         S_WAIT_START: begin
            if (m_busy) begin
               cnt_d   = '0;
               state_d = S_WAIT_DONE;
            end else if (cnt_inc_c == TIMEOUT_CYCLES) begin
               cnt_d   = cnt_inc_c;
               err_d   = 3'b100;
               state_d = S_RESPOND;
            end else begin
               cnt_d = cnt_inc_c;
            end
         end
         S_WAIT_DONE: begin
            if (!m_busy) begin
               rdata_d = m_data_out;
               err_d   = {2'b00, nack_c};
               state_d = S_RESPOND;
            end else if (cnt_inc_c == TIMEOUT_CYCLES) begin
               cnt_d   = cnt_inc_c;
               err_d   = 3'b100;
               state_d = S_RESPOND;
            end else begin
               cnt_d = cnt_inc_c;
            end
         end
         S_RESPOND: begin
            last_d  = winner_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // Registered status outputs follow the state being entered
   always_comb begin
      done_d    = (state_d == S_RESPOND) ? {winner_d, ~winner_d} : 2'b00;
      busy_d    = (state_d != S_IDLE);
      m_reset_d = (state_d == S_IDLE) || (state_d == S_RESPOND);
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         addr_q    <= '0;
         mask_q    <= '0;
         wdata_q   <= '0;
         write_q   <= 1'b0;
         winner_q  <= 1'b0;
         last_q    <= 1'b1;
         cnt_q     <= '0;
         done_q    <= '0;
         rdata_q   <= '0;
         err_q     <= '0;
         busy_q    <= 1'b0;
         m_reset_q <= 1'b1;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         mask_q    <= mask_d;
         wdata_q   <= wdata_d;
         write_q   <= write_d;
         winner_q  <= winner_d;
         last_q    <= last_d;
         cnt_q     <= cnt_d;
         done_q    <= done_d;
         rdata_q   <= rdata_d;
         err_q     <= err_d;
         busy_q    <= busy_d;
         m_reset_q <= m_reset_d;
      end
   end

   assign done          = done_q;
   assign rdata         = rdata_q;
   assign err           = err_q;
   assign ctrl_busy     = busy_q;
   assign m_reset       = m_reset_q;
   assign m_device_addr = addr_q;
   assign m_mask        = mask_q;
   assign m_data_in     = wdata_q;
   assign m_write       = write_q;

endmodule

// File: tb/tb_i2c_arbiter.sv
// Directed bench for i2c_arbiter with a small behavioral I2C master stand-in.
`timescale 1ns/1ps
module tb_i2c_arbiter;

   logic        clk;
   logic        reset_n;
   logic [1:0]  req;
   logic [1:0]  req_write;
   logic [13:0] req_addr;
   logic [7:0]  req_mask;
   logic [63:0] req_wdata;
   logic [1:0]  done;
   logic [31:0] rdata;
   logic [2:0]  err;
   logic        ctrl_busy;
   logic        m_reset;
   logic [6:0]  m_device_addr;
   logic [3:0]  m_mask;
   logic [31:0] m_data_in;
   logic        m_write;
   logic        m_busy;
   logic [31:0] m_data_out;
   logic [4:0]  m_acks;

   int          n_checks;
   int          n_pass;
   logic        stuck;
   logic        saw_mrst_low;
   logic [3:0]  mcnt;

   i2c_arbiter #(.TIMEOUT_CYCLES(24'd100)) dut (
      .clk(clk), .reset_n(reset_n),
      .req(req), .req_write(req_write), .req_addr(req_addr),
      .req_mask(req_mask), .req_wdata(req_wdata),
      .done(done), .rdata(rdata), .err(err), .ctrl_busy(ctrl_busy),
      .m_reset(m_reset), .m_device_addr(m_device_addr), .m_mask(m_mask),
      .m_data_in(m_data_in), .m_write(m_write),
      .m_busy(m_busy), .m_data_out(m_data_out), .m_acks(m_acks)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Master stand-in: busy for four cycles starting two cycles after release
   always @(posedge clk) begin
      if (m_reset) mcnt <= 4'd0;
      else if (mcnt != 4'd15) mcnt <= mcnt + 4'd1;
   end
   assign m_busy = stuck | ((mcnt >= 4'd2) && (mcnt < 4'd6));

   always @(posedge clk) if (!m_reset) saw_mrst_low <= 1'b1;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
   endtask

   task automatic set_req(input int k, input logic wr, input logic [6:0] a,
                          input logic [3:0] m, input logic [31:0] d);
      if (k == 0) begin
         req_write[0] = wr; req_addr[6:0] = a; req_mask[3:0] = m; req_wdata[31:0] = d;
      end else begin
         req_write[1] = wr; req_addr[13:7] = a; req_mask[7:4] = m; req_wdata[63:32] = d;
      end
   endtask

   task automatic wait_done(input int max, output logic [1:0] d, output int cyc);
      d = 2'b00;
      cyc = 0;
      while (d == 2'b00 && cyc < max) begin
         @(negedge clk);
         cyc++;
         d = done;
      end
   endtask

   logic [1:0] d;
   int         cyc;
   logic [1:0] exp_order [4];
   logic       any_done;

   initial begin
      n_checks = 0; n_pass = 0;
      stuck = 1'b0; saw_mrst_low = 1'b0;
      req = 2'b00; req_write = 2'b00; req_addr = '0; req_mask = '0; req_wdata = '0;
      m_data_out = '0; m_acks = '0;
      exp_order[0] = 2'b01; exp_order[1] = 2'b10; exp_order[2] = 2'b01; exp_order[3] = 2'b10;
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_done", 32'(done), 32'h0);
      check("rst_mreset", 32'(m_reset), 32'h1);
      check("rst_busy", 32'(ctrl_busy), 32'h0);
      check("rst_err", 32'(err), 32'h0);
      check("rst_rdata", rdata, 32'h0);
      check("rst_maddr", 32'(m_device_addr), 32'h0);
      reset_n = 1'b1;

      // Write from requester 0, all bytes ACKed
      saw_mrst_low = 1'b0;
      set_req(0, 1'b1, 7'h50, 4'hF, 32'hDEADBEEF);
      req = 2'b01;
      wait_done(50, d, cyc);
      check("wr_done", 32'(d), 32'h1);
      check("wr_err", 32'(err), 32'h0);
      check("wr_mreset_low", 32'(saw_mrst_low), 32'h1);
      check("wr_addr", 32'(m_device_addr), 32'h50);
      check("wr_data", m_data_in, 32'hDEADBEEF);
      check("wr_write", 32'(m_write), 32'h1);
      req = 2'b00;
      @(negedge clk);
      check("wr_pulse_1cyc", 32'(done), 32'h0);
      check("wr_idle_busy", 32'(ctrl_busy), 32'h0);

      // Read from requester 1, byte acks ignored on reads
      set_req(1, 1'b0, 7'h21, 4'b0011, 32'h0);
      m_data_out = 32'h0000_1234; m_acks = 5'b01100;
      req = 2'b10;
      wait_done(50, d, cyc);
      check("rd_done", 32'(d), 32'h2);
      check("rd_data", 32'(rdata[15:0]), 32'h1234);
      check("rd_err", 32'(err), 32'h0);
      req = 2'b00;
      m_acks = '0;
      @(negedge clk);

      // Fresh reset, then both requesters held: alternate starting with 0
      reset_n = 1'b0;
      @(negedge clk);
      reset_n = 1'b1;
      set_req(0, 1'b0, 7'h11, 4'hF, 32'h0);
      set_req(1, 1'b0, 7'h22, 4'hF, 32'h0);
      req = 2'b11;
      for (int i = 0; i < 4; i++) begin
         wait_done(50, d, cyc);
         check($sformatf("rr_%0d", i), 32'(d), 32'(exp_order[i]));
      end
      req = 2'b00;
      @(negedge clk);
      check("rr_single_done", 32'(done), 32'h0);

      // NACK on address
      set_req(0, 1'b1, 7'h30, 4'hF, 32'h1);
      m_acks = 5'b10000;
      req = 2'b01;
      wait_done(50, d, cyc);
      check("nack_addr", 32'(err), 32'h1);
      req = 2'b00; @(negedge clk);

      // Write NACK on enabled byte 2
      m_acks = 5'b00100;
      req = 2'b01;
      wait_done(50, d, cyc);
      check("nack_byte2", 32'(err), 32'h1);
      req = 2'b00; @(negedge clk);

      // Byte 2 NACK ignored when its mask bit is clear
      set_req(0, 1'b1, 7'h30, 4'b1011, 32'h1);
      m_data_out = 32'hCAFE_0001;
      req = 2'b01;
      wait_done(50, d, cyc);
      check("nack_masked", 32'(err), 32'h0);
      req = 2'b00; @(negedge clk);
      m_acks = '0;

      // Zero mask skips the master entirely
      saw_mrst_low = 1'b0;
      set_req(0, 1'b1, 7'h30, 4'b0000, 32'h1);
      req = 2'b01;
      wait_done(3, d, cyc);
      check("mz_done", 32'(d), 32'h1);
      check("mz_err", 32'(err), 32'h2);
      req = 2'b00; @(negedge clk);
      check("mz_mreset_high", 32'(saw_mrst_low), 32'h0);

      // Master stuck busy: abort after 100 counted cycles, rdata kept
      stuck = 1'b1;
      m_data_out = 32'h5555_5555;
      set_req(0, 1'b0, 7'h30, 4'hF, 32'h0);
      req = 2'b01;
      wait_done(200, d, cyc);
      check("to_done", 32'(d), 32'h1);
      check("to_err", 32'(err), 32'h4);
      check("to_latency", 32'(cyc), 32'd103);
      check("to_rdata_kept", rdata, 32'hCAFE_0001);
      req = 2'b00; stuck = 1'b0;
      @(negedge clk);

      // Reset while waiting for the master to finish
      set_req(0, 1'b1, 7'h44, 4'hF, 32'h7);
      req = 2'b01;
      cyc = 0;
      while (!m_busy && cyc < 20) begin @(negedge clk); cyc++; end
      check("rmid_reached_busy", 32'(m_busy), 32'h1);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      check("rmid_mreset", 32'(m_reset), 32'h1);
      check("rmid_busy", 32'(ctrl_busy), 32'h0);
      check("rmid_done", 32'(done), 32'h0);
      req = 2'b00;
      @(negedge clk);
      reset_n = 1'b1;
      any_done = 1'b0;
      repeat (10) begin @(negedge clk); if (done != 2'b00) any_done = 1'b1; end
      check("rmid_no_done", 32'(any_done), 32'h0);
      set_req(1, 1'b0, 7'h12, 4'hF, 32'h0);
      m_data_out = 32'hA5A5_0F0F;
      req = 2'b10;
      wait_done(50, d, cyc);
      check("post_rst_done", 32'(d), 32'h2);
      check("post_rst_rdata", rdata, 32'hA5A5_0F0F);
      check("post_rst_err", 32'(err), 32'h0);
      req = 2'b00;
      @(negedge clk);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
